// File: rtl/accel_run_sequencer_pkg.sv
// rtl/accel_run_sequencer_pkg.sv - shared state, lane and size constants for the run sequencer
package accel_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        START,
        RUN,
        RD_REQ,
        RD_WAIT,
        RD_OUT,
        FIN
    } seq_state_t;

    // Only one lane of the dual-lane slave port is ever driven.
    localparam int LANE = 0;
    localparam logic [1:0] LANE_MASK = 2'(1 << LANE);

    // The slave size field carries the access width in bits.
    function automatic logic [7:0] size_enc(input int bits);
        return 8'(bits);
    endfunction

endpackage

// File: rtl/accel_run_sequencer_if.sv
// rtl/accel_run_sequencer_if.sv - dual-lane accelerator slave memory port
interface accel_run_sequencer_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic [1:0]          s_oe;
    logic [1:0]          s_we;
    logic [ADDR_W-1:0]   s_addr;
    logic [2*DATA_W-1:0] s_wdata;
    logic [7:0]          s_size;
    logic [2*DATA_W-1:0] s_rdata;
    logic [1:0]          s_rdy;

    modport master (
        output s_oe, s_we, s_addr, s_wdata, s_size,
        input  s_rdata, s_rdy
    );

    modport slave (
        input  s_oe, s_we, s_addr, s_wdata, s_size,
        output s_rdata, s_rdy
    );
endinterface

// File: rtl/accel_run_sequencer_counter.sv
// rtl/accel_run_sequencer_counter.sv - run-length cycle counter with timeout terminal flag
module run_cycle_counter #(
    parameter int CYC_W   = 32,
    parameter int TIMEOUT = 200000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count,
    output logic             tc
);
    // Count enabled cycles; clear restarts the run from zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CYC_W'(1);
        end
    end

    // Flags the cycle whose completion would reach the timeout length.
    assign tc = ((count + CYC_W'(1)) == CYC_W'(TIMEOUT));
endmodule

// File: rtl/accel_run_sequencer.sv
// rtl/accel_run_sequencer.sv - preload, start, time and read back one accelerator run
module accel_run_sequencer
    import accel_seq_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int CYC_W   = 32,
    parameter int TIMEOUT = 200000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_W-1:0]     cfg_ld_base,
    input  logic [15:0]           cfg_ld_len,
    input  logic [ADDR_W-1:0]     cfg_rd_base,
    input  logic [15:0]           cfg_rd_len,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  acc_start,
    input  logic                  acc_done,
    accel_run_sequencer_if.master mem,
    output logic                  busy,
    output logic                  run_done,
    output logic                  timed_out,
    output logic [CYC_W-1:0]      cycles
);
    localparam logic [7:0] REQ_SIZE = size_enc(DATA_W);

    seq_state_t        state;
    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       ld_rem;
    logic [15:0]       rd_rem;
    logic [CYC_W-1:0]  run_count;
    logic              run_tc;

    // Upper lane of the slave port is never requested, so its returns are dropped.
    logic unused_upper;
    assign unused_upper = ^{mem.s_rdata[2*DATA_W-1:DATA_W], mem.s_rdy[1]};

    run_cycle_counter #(
        .CYC_W   (CYC_W),
        .TIMEOUT (TIMEOUT)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == START),
        .enable (state == RUN),
        .count  (run_count),
        .tc     (run_tc)
    );

    // Sequencer FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ld_ptr      <= '0;
            rd_ptr      <= '0;
            ld_rem      <= '0;
            rd_rem      <= '0;
            ld_ready    <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            acc_start   <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            timed_out   <= 1'b0;
            cycles      <= '0;
            mem.s_oe    <= '0;
            mem.s_we    <= '0;
            mem.s_addr  <= '0;
            mem.s_wdata <= '0;
            mem.s_size  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        ld_ptr    <= cfg_ld_base;
                        ld_rem    <= cfg_ld_len;
                        rd_ptr    <= cfg_rd_base;
                        rd_rem    <= cfg_rd_len;
                        timed_out <= 1'b0;
                        cycles    <= '0;
                        busy      <= 1'b1;
                        if (cfg_ld_len == 16'd0) begin
                            acc_start <= 1'b1;
                            state     <= START;
                        end else begin
                            ld_ready <= 1'b1;
                            state    <= LD_REQ;
                        end
                    end
                end
                LD_REQ: begin
                    if (ld_valid) begin
                        ld_ready    <= 1'b0;
                        mem.s_we    <= LANE_MASK;
                        mem.s_addr  <= ld_ptr;
                        mem.s_wdata <= {{DATA_W{1'b0}}, ld_data};
                        mem.s_size  <= REQ_SIZE;
                        state       <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    mem.s_we   <= '0;
                    mem.s_size <= '0;
                    if (mem.s_rdy[LANE]) begin
                        ld_ptr <= ld_ptr + ADDR_W'(1);
                        ld_rem <= ld_rem - 16'd1;
                        if (ld_rem != 16'd1) begin
                            ld_ready <= 1'b1;
                            state    <= LD_REQ;
                        end else begin
                            acc_start <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    acc_start <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (acc_done) begin
                        cycles <= run_count + CYC_W'(1);
                        if (rd_rem == 16'd0) begin
                            run_done <= 1'b1;
                            state    <= FIN;
                        end else begin
                            mem.s_oe   <= LANE_MASK;
                            mem.s_addr <= rd_ptr;
                            mem.s_size <= REQ_SIZE;
                            state      <= RD_REQ;
                        end
                    end else if (run_tc) begin
                        timed_out <= 1'b1;
                        cycles    <= CYC_W'(TIMEOUT);
                        run_done  <= 1'b1;
                        state     <= FIN;
                    end
                end
                RD_REQ: begin
                    mem.s_oe   <= '0;
                    mem.s_size <= '0;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem.s_rdy[LANE]) begin
                        rd_data  <= mem.s_rdata[DATA_W-1:0];
                        rd_valid <= 1'b1;
                        rd_ptr   <= rd_ptr + ADDR_W'(1);
                        rd_rem   <= rd_rem - 16'd1;
                        state    <= RD_OUT;
                    end
                end
                RD_OUT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (rd_rem != 16'd0) begin
                            mem.s_oe   <= LANE_MASK;
                            mem.s_addr <= rd_ptr;
                            mem.s_size <= REQ_SIZE;
                            state      <= RD_REQ;
                        end else begin
                            run_done <= 1'b1;
                            state    <= FIN;
                        end
                    end
                end
                FIN: begin
                    run_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
